// File: rtl/mm_codebreaker.sv
// ============================================================================
//  Module   : mm_codebreaker
//  Purpose  : Autonomous Mastermind guesser (4 digits x 8 colours). Each new
//             guess is the lowest code consistent with every stored
//             (guess, red, white) history entry.
//  Ports    : clk, resetn (sync, active-low), start (new game pulse)
//             guess[11:0] / guess_valid / guess_ready : guess handshake
//             fb_valid / fb_red[2:0] / fb_white[2:0]  : feedback input
//             guess_count[3:0], busy, solved, fail    : status
//  Options  : MM_CODEBREAKER_OPENER_EN - first guess is the fixed opener
//             12'h240 instead of a searched code.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_codebreaker #(
  parameter int MAX_GUESSES = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [11:0] guess,
  output logic        guess_valid,
  input  logic        guess_ready,
  input  logic        fb_valid,
  input  logic [2:0]  fb_red,
  input  logic [2:0]  fb_white,
  output logic [3:0]  guess_count,
  output logic        busy,
  output logic        solved,
  output logic        fail
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_OFFER   = 3'd2,
    ST_WAIT_FB = 3'd3,
    ST_SOLVED  = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  localparam logic [3:0]  MAX_CNT  = 4'(MAX_GUESSES);
  localparam logic [11:0] LAST_CODE = 12'hFFF;
  localparam logic [11:0] OPENER    = 12'h240;

  state_t      state, state_next;
  logic [11:0] candidate;
  logic [3:0]  hidx;      // history entry being checked
  logic [3:0]  hist_n;    // number of stored (guess, feedback) entries

  // Full 4-bit addressable history; only the first MAX_GUESSES are used.
  logic [11:0] hist_guess [0:15];
  logic [2:0]  hist_red   [0:15];
  logic [2:0]  hist_white [0:15];

  logic [2:0]  sc_red, sc_white;
  logic        match, last_entry, accept_cand, out_of_codes;

  // Red = positional matches; white = colour-overlap total minus red.
  function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] red, total, ca, cb;
    red   = 3'd0;
    total = 3'd0;
    for (int i = 0; i < 4; i++)
      if (a[3*i +: 3] == b[3*i +: 3]) red = red + 3'd1;
    for (int c = 0; c < 8; c++) begin
      ca = 3'd0;
      cb = 3'd0;
      for (int i = 0; i < 4; i++) begin
        if (a[3*i +: 3] == 3'(c)) ca = ca + 3'd1;
        if (b[3*i +: 3] == 3'(c)) cb = cb + 3'd1;
      end
      total = total + ((ca < cb) ? ca : cb);
    end
    return {red, total - red};
  endfunction

  always_comb begin
    {sc_red, sc_white} = score(candidate, hist_guess[hidx]);
    match       = (sc_red == hist_red[hidx]) && (sc_white == hist_white[hidx]);
    last_entry  = (hidx == hist_n - 4'd1);
    accept_cand = (hist_n == 4'd0) || (match && last_entry);
    // No higher code exists to resume from after a failed guess of FFF.
    out_of_codes = (guess_count == MAX_CNT) || (guess == LAST_CODE);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    guess_valid = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_SEARCH: begin
        busy = 1'b1;
        if (accept_cand)                    state_next = ST_OFFER;
        else if (candidate == LAST_CODE)    state_next = ST_FAIL;
      end
      ST_OFFER: begin
        busy        = 1'b1;
        guess_valid = 1'b1;
        if (guess_ready) state_next = ST_WAIT_FB;
      end
      ST_WAIT_FB: begin
        busy = 1'b1;
        if (fb_valid) begin
          if (fb_red == 3'd4)    state_next = ST_SOLVED;
          else if (out_of_codes) state_next = ST_FAIL;
          else                   state_next = ST_SEARCH;
        end
      end
      default: ;
    endcase
    if (start) state_next = ST_SEARCH;
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!resetn) begin
      candidate   <= 12'h000;
      hidx        <= 4'd0;
      hist_n      <= 4'd0;
      guess       <= 12'h000;
      guess_count <= 4'd0;
      solved      <= 1'b0;
      fail        <= 1'b0;
    end else if (start) begin
      candidate   <= 12'h000;
      hidx        <= 4'd0;
      hist_n      <= 4'd0;
      guess_count <= 4'd0;
      solved      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (hist_n == 4'd0) begin
`ifdef MM_CODEBREAKER_OPENER_EN
            guess <= OPENER;
`else
            guess <= candidate;
`endif
          end else if (match) begin
            if (last_entry) guess <= candidate;
            else            hidx  <= hidx + 4'd1;
          end else begin
            hidx <= 4'd0;
            if (candidate == LAST_CODE) fail      <= 1'b1;
            else                        candidate <= candidate + 12'd1;
          end
        end
        ST_OFFER: begin
          if (guess_ready) guess_count <= guess_count + 4'd1;
        end
        ST_WAIT_FB: begin
          if (fb_valid) begin
            hist_n <= hist_n + 4'd1;
            hidx   <= 4'd0;
            if (fb_red == 3'd4)    solved <= 1'b1;
            else if (out_of_codes) fail   <= 1'b1;
            else begin
`ifdef MM_CODEBREAKER_OPENER_EN
              // The opener skipped the search, so nothing below it is rejected yet.
              candidate <= (hist_n == 4'd0) ? 12'h000 : guess + 12'd1;
`else
              candidate <= guess + 12'd1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  // History storage needs no reset: entries beyond hist_n are never read.
  always_ff @(posedge clk) begin
    if (resetn && !start) begin
      if (state == ST_OFFER && guess_ready)
        hist_guess[hist_n] <= guess;
      if (state == ST_WAIT_FB && fb_valid) begin
        hist_red[hist_n]   <= fb_red;
        hist_white[hist_n] <= fb_white;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mm_codebreaker.sv
// ============================================================================
//  Module   : tb_mm_codebreaker
//  Purpose  : Self-checking bench for mm_codebreaker (default build). A
//             second instance with MAX_GUESSES=2 shares all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mm_codebreaker;

  logic        clk = 1'b0;
  logic        resetn, start, guess_ready, fb_valid;
  logic [2:0]  fb_red, fb_white;
  logic [11:0] guess, d2_guess;
  logic        guess_valid, busy, solved, fail;
  logic        d2_valid, d2_busy, d2_solved, d2_fail;
  logic [3:0]  guess_count, d2_count;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  mm_codebreaker dut (
    .clk(clk), .resetn(resetn), .start(start),
    .guess(guess), .guess_valid(guess_valid), .guess_ready(guess_ready),
    .fb_valid(fb_valid), .fb_red(fb_red), .fb_white(fb_white),
    .guess_count(guess_count), .busy(busy), .solved(solved), .fail(fail)
  );

  mm_codebreaker #(.MAX_GUESSES(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start),
    .guess(d2_guess), .guess_valid(d2_valid), .guess_ready(guess_ready),
    .fb_valid(fb_valid), .fb_red(fb_red), .fb_white(fb_white),
    .guess_count(d2_count), .busy(d2_busy), .solved(d2_solved), .fail(d2_fail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_fb(input logic [2:0] r, input logic [2:0] w);
    fb_valid = 1'b1;
    fb_red   = r;
    fb_white = w;
    tick();
    fb_valid = 1'b0;
  endtask

  // Waits (bounded) for an offer, then pops the scoreboard and compares.
  task automatic wait_offer(input string tag, input int limit, output int cyc);
    logic [11:0] e;
    cyc = 0;
    while (guess_valid !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    chk({tag, "_valid"}, guess_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_guess"}, guess, e);
    end
  endtask

  task automatic accept();
    tick();
    chk("accept_valid_low", guess_valid, 1'b0);
  endtask

  initial begin
    int cyc;
    logic saw_valid;
    resetn = 1'b0; start = 1'b0; guess_ready = 1'b1;
    fb_valid = 1'b0; fb_red = 3'd0; fb_white = 3'd0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("rst_guess", guess, 12'h000);
    chk("rst_valid", guess_valid, 1'b0);
    chk("rst_count", guess_count, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_solved", solved, 1'b0);
    chk("rst_fail", fail, 1'b0);

    // Secret 000: solved on the first guess.
    pulse_start();
    exp_q.push_back(12'h000);
    chk("t1_busy_search", busy, 1'b1);
    chk("t1_valid_search", guess_valid, 1'b0);
    wait_offer("t1_g0", 20, cyc);
    chk("t1_latency", cyc, 1);
    accept();
    chk("t1_count_wait", guess_count, 4'd1);
    send_fb(3'd4, 3'd0);
    chk("t1_solved", solved, 1'b1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_count", guess_count, 4'd1);

    // Secret 001: 3/0 on 000 leads directly to 001.
    pulse_start();
    chk("t2_solved_clr", solved, 1'b0);
    exp_q.push_back(12'h000);
    wait_offer("t2_g0", 20, cyc);
    accept();
    send_fb(3'd3, 3'd0);
    exp_q.push_back(12'h001);
    wait_offer("t2_g1", 20, cyc);
    chk("t2_latency", cyc, 1);
    accept();
    send_fb(3'd4, 3'd0);
    chk("t2_solved", solved, 1'b1);
    chk("t2_count", guess_count, 4'd2);

    // Impossible feedback: every remaining code is rejected.
    pulse_start();
    exp_q.push_back(12'h000);
    wait_offer("t3_g0", 20, cyc);
    accept();
    send_fb(3'd0, 3'd1);
    cyc = 0;
    saw_valid = 1'b0;
    while (fail !== 1'b1 && cyc < 5000) begin
      tick();
      cyc++;
      if (guess_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("t3_fail", fail, 1'b1);
    chk("t3_cycles", cyc, 4095);
    chk("t3_busy", busy, 1'b0);
    chk("t3_no_offer", saw_valid, 1'b0);
    chk("t3_count", guess_count, 4'd1);

    // Guess limit on the MAX_GUESSES=2 instance.
    pulse_start();
    exp_q.push_back(12'h000);
    wait_offer("t4_g0", 20, cyc);
    chk("t4_d2_g0", d2_guess, 12'h000);
    accept();
    send_fb(3'd0, 3'd0);
    chk("t4_d2_fail_early", d2_fail, 1'b0);
    exp_q.push_back(12'h249);
    wait_offer("t4_g1", 5000, cyc);
    chk("t4_d2_valid", d2_valid, 1'b1);
    chk("t4_d2_g1", d2_guess, 12'h249);
    accept();
    send_fb(3'd0, 3'd0);
    chk("t4_d2_fail", d2_fail, 1'b1);
    chk("t4_d2_count", d2_count, 4'd2);
    chk("t4_d2_busy", d2_busy, 1'b0);
    chk("t4_d1_busy", busy, 1'b1);

    // Back-pressure in OFFER, then restart in the middle of a search.
    guess_ready = 1'b0;
    pulse_start();
    exp_q.push_back(12'h000);
    wait_offer("t5_g0", 20, cyc);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_valid", guess_valid, 1'b1);
      chk("t5_hold_guess", guess, 12'h000);
    end
    chk("t5_count_hold", guess_count, 4'd0);
    guess_ready = 1'b1;
    accept();
    send_fb(3'd0, 3'd0);
    repeat (100) tick();
    chk("t5_mid_busy", busy, 1'b1);
    chk("t5_mid_valid", guess_valid, 1'b0);
    pulse_start();
    exp_q.push_back(12'h000);
    wait_offer("t5_r0", 20, cyc);
    chk("t5_r_latency", cyc, 1);
    chk("t5_r_count", guess_count, 4'd0);
    accept();
    send_fb(3'd3, 3'd0);
    exp_q.push_back(12'h001);
    wait_offer("t5_r1", 20, cyc);
    chk("t5_r1_latency", cyc, 1);
    accept();
    send_fb(3'd4, 3'd0);
    chk("t5_solved", solved, 1'b1);
    chk("t5_count", guess_count, 4'd2);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
